// File: rtl/lamp_seq_pkg.sv
// Shared constants and helpers for the lamp-bank sequencer family.
// Holds the mode encodings and a constant-evaluable ceil(log2) for width derivation.
package lamp_seq_pkg;

  localparam logic [1:0] MODE_CLEAR    = 2'b00;
  localparam logic [1:0] MODE_SATURATE = 2'b01;
  localparam logic [1:0] MODE_DECAY    = 2'b10;
  localparam logic [1:0] MODE_HOLD     = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lamp_thermo_decode.sv
// Level-to-thermometer lamp decode, purely combinational and shared by all lamp banks.
// Lamp i lights when i < ceil(level*LAMPS/NUM_LEVELS), evaluated without a divider.
module lamp_thermo_decode
  import lamp_seq_pkg::*;
#(
  parameter int NUM_LEVELS = 3,
  parameter int LAMPS      = 5,
  parameter int LVL_W      = clog2(NUM_LEVELS + 1)
) (
  input  logic [LVL_W-1:0] level,
  output logic [LAMPS-1:0] lamps
);

  // i < ceil(a/b) is equivalent to i*b < a for non-negative integers
  always_comb begin
    lamps = '0;
    for (int i = 0; i < LAMPS; i++) begin
      if (i * NUM_LEVELS < int'(level) * LAMPS) begin
        lamps[i] = 1'b1;
      end else begin
        lamps[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/lamp_bar_sequencer.sv
// Bar-graph lamp sequencer: level steps 0..NUM_LEVELS under switch control, one step per DWELL clocks.
// Mode selects what releasing the switch and reaching the top do.
module lamp_bar_sequencer
  import lamp_seq_pkg::*;
#(
  parameter int NUM_LEVELS = 3,
  parameter int LAMPS      = 5,
  parameter int DWELL      = 1,
  parameter int LVL_W      = clog2(NUM_LEVELS + 1)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             sw,
  input  logic [1:0]       mode,
  output logic [LAMPS-1:0] lamps,
  output logic [LVL_W-1:0] level,
  output logic             at_top,
  output logic             wrap_pulse
);

  localparam int TMR_W = (DWELL > 1) ? clog2(DWELL) : 1;
  localparam logic [LVL_W-1:0] TOP  = LVL_W'(NUM_LEVELS);
  localparam logic [TMR_W-1:0] LAST = TMR_W'(DWELL - 1);

  logic [LVL_W-1:0] level_q, level_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [TMR_W-1:0] timer_eff_s;
  logic [1:0]       mode_q;
  logic             sw_q;
  logic             wrap_q, wrap_d;

  // Next level, dwell timer and wrap strobe; a mode or direction change discards any partial dwell
  always_comb begin
    level_d     = level_q;
    timer_d     = '0;
    wrap_d      = 1'b0;
    if ((mode != mode_q) || (sw != sw_q)) begin
      timer_eff_s = '0;
    end else begin
      timer_eff_s = timer_q;
    end
    if (sw) begin
      if ((level_q != TOP) || (mode == MODE_CLEAR)) begin
        if (timer_eff_s == LAST) begin
          if (level_q == TOP) begin
            level_d = '0;
            wrap_d  = 1'b1;
          end else begin
            level_d = level_q + LVL_W'(1);
          end
        end else begin
          timer_d = timer_eff_s + TMR_W'(1);
        end
      end else begin
        level_d = level_q;
      end
    end else begin
      case (mode)
        MODE_CLEAR, MODE_SATURATE: level_d = '0;
        MODE_DECAY: begin
          if (level_q != '0) begin
            if (timer_eff_s == LAST) begin
              level_d = level_q - LVL_W'(1);
            end else begin
              timer_d = timer_eff_s + TMR_W'(1);
            end
          end else begin
            level_d = level_q;
          end
        end
        MODE_HOLD: level_d = level_q;
        default:   level_d = level_q;
      endcase
    end
  end

  // State registers; reset dominates and re-captures mode so it is not seen as a change
  always_ff @(posedge CLK) begin
    if (reset) begin
      level_q <= '0;
      timer_q <= '0;
      wrap_q  <= 1'b0;
      mode_q  <= mode;
      sw_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      timer_q <= timer_d;
      wrap_q  <= wrap_d;
      mode_q  <= mode;
      sw_q    <= sw;
    end
  end

  assign level      = level_q;
  assign at_top     = (level_q == TOP);
  assign wrap_pulse = wrap_q;

  lamp_thermo_decode #(
    .NUM_LEVELS (NUM_LEVELS),
    .LAMPS      (LAMPS),
    .LVL_W      (LVL_W)
  ) u_decode (
    .level (level_q),
    .lamps (lamps)
  );

endmodule

// File: tb/tb_lamp_bar_sequencer.sv
// Bench for lamp_bar_sequencer: DWELL=1 and DWELL=4 instances share stimulus; a request-age model
// feeds per-instance scoreboards, and directed scenarios add fixed expectations.
module tb_lamp_bar_sequencer;
  import lamp_seq_pkg::*;

  localparam int NL   = 3;
  localparam int NLMP = 5;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       reset = 1'b1;
  logic       sw    = 1'b0;
  logic [1:0] mode  = MODE_CLEAR;

  logic [4:0] lamps1, lamps4;
  logic [1:0] level1, level4;
  logic       top1, top4, wrap1, wrap4;

  lamp_bar_sequencer #(.NUM_LEVELS(NL), .LAMPS(NLMP), .DWELL(1)) u_d1 (
    .CLK(CLK), .reset(reset), .sw(sw), .mode(mode),
    .lamps(lamps1), .level(level1), .at_top(top1), .wrap_pulse(wrap1));

  lamp_bar_sequencer #(.NUM_LEVELS(NL), .LAMPS(NLMP), .DWELL(4)) u_d4 (
    .CLK(CLK), .reset(reset), .sw(sw), .mode(mode),
    .lamps(lamps4), .level(level4), .at_top(top4), .wrap_pulse(wrap4));

  typedef struct packed {
    logic [1:0] lvl;
    logic [4:0] lamps;
    logic       top;
    logic       wrap;
  } obs_t;

  obs_t q1[$];
  obs_t q4[$];
  int errors = 0;
  int checks = 0;

  // Model state: level, age of the current request, previous request kind and mode
  int         dw[2] = '{1, 4};
  int         m_lvl[2];
  int         m_age[2];
  int         m_req[2];
  logic [1:0] m_mode[2];

  // req: 0 none, 1 up, 2 down, 3 clear-to-zero
  function automatic obs_t model(int k, bit rst, bit s, logic [1:0] md);
    obs_t o;
    int   req;
    bit   wr;
    wr = 1'b0;
    if (rst) begin
      m_lvl[k] = 0;
      m_age[k] = 0;
      req = 0;
    end else begin
      if (s) req = (m_lvl[k] < NL || md == MODE_CLEAR) ? 1 : 0;
      else if (md == MODE_CLEAR || md == MODE_SATURATE) req = 3;
      else if (md == MODE_DECAY && m_lvl[k] > 0) req = 2;
      else req = 0;
      if (req == 1 || req == 2) begin
        m_age[k] = (req == m_req[k] && md == m_mode[k]) ? m_age[k] + 1 : 1;
        if (m_age[k] == dw[k]) begin
          m_age[k] = 0;
          if (req == 2) m_lvl[k] = m_lvl[k] - 1;
          else if (m_lvl[k] == NL) begin m_lvl[k] = 0; wr = 1'b1; end
          else m_lvl[k] = m_lvl[k] + 1;
        end
      end else begin
        m_age[k] = 0;
        if (req == 3) m_lvl[k] = 0;
      end
    end
    m_req[k]  = req;
    m_mode[k] = md;
    o.lvl   = 2'(m_lvl[k]);
    o.lamps = 5'((1 << ((m_lvl[k] * NLMP + NL - 1) / NL)) - 1);
    o.top   = (m_lvl[k] == NL);
    o.wrap  = wr;
    return o;
  endfunction

  task automatic cyc(bit r, bit s, logic [1:0] md);
    @(negedge CLK);
    reset = r;
    sw    = s;
    mode  = md;
    q1.push_back(model(0, r, s, md));
    q4.push_back(model(1, r, s, md));
  endtask

  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one expectation is consumed per edge
  initial begin
    obs_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checks++;
        if ({level1, lamps1, top1, wrap1} !== e) begin
          errors++;
          $display("FAIL sb_dwell1 t=%0t got lvl=%0d lamps=%b top=%b wrap=%b exp lvl=%0d lamps=%b top=%b wrap=%b",
                   $time, level1, lamps1, top1, wrap1, e.lvl, e.lamps, e.top, e.wrap);
        end
      end
      if (q4.size() > 0) begin
        e = q4.pop_front();
        checks++;
        if ({level4, lamps4, top4, wrap4} !== e) begin
          errors++;
          $display("FAIL sb_dwell4 t=%0t got lvl=%0d lamps=%b top=%b wrap=%b exp lvl=%0d lamps=%b top=%b wrap=%b",
                   $time, level4, lamps4, top4, wrap4, e.lvl, e.lamps, e.top, e.wrap);
        end
      end
    end
  end

  initial begin
    int         exp_l[5]  = '{1, 2, 3, 0, 1};
    int         exp_lp[5] = '{3, 15, 31, 0, 3};
    bit         r_s;
    bit         s_s;
    logic [1:0] md_s;

    // Reset state
    cyc(1'b1, 1'b0, MODE_CLEAR);
    cyc(1'b1, 1'b0, MODE_CLEAR);
    settle();
    chk("reset_level", level1, 0);
    chk("reset_lamps", lamps1, 0);
    chk("reset_at_top", top1, 0);

    // CLEAR wrap sequence at DWELL=1
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, MODE_CLEAR);
      settle();
      chk("clear_level", level1, exp_l[i]);
      chk("clear_lamps", lamps1, exp_lp[i]);
      chk("clear_wrap", wrap1, (i == 3) ? 1 : 0);
    end

    // SATURATE holds top, release clears in one clock
    cyc(1'b1, 1'b0, MODE_SATURATE);
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b0, 1'b1, MODE_SATURATE);
      settle();
      chk("sat_level", level1, (i < 3) ? i : 3);
      chk("sat_at_top", top1, (i >= 3) ? 1 : 0);
    end
    cyc(1'b0, 1'b0, MODE_SATURATE);
    settle();
    chk("sat_release", level1, 0);

    // DECAY at DWELL=4: up in 12 clocks, down one level per 4 clocks
    cyc(1'b1, 1'b0, MODE_DECAY);
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b0, 1'b1, MODE_DECAY);
      settle();
      if (i == 11) chk("decay_up_11", level4, 2);
      if (i == 12) chk("decay_up_12", level4, 3);
    end
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 1'b0, MODE_DECAY);
      settle();
      if (i == 3)  chk("decay_dn_3", level4, 3);
      if (i == 4)  chk("decay_dn_4", level4, 2);
      if (i == 8)  chk("decay_dn_8", level4, 1);
      if (i == 12) chk("decay_dn_12", level4, 0);
      if (i == 16) chk("decay_dn_16", level4, 0);
    end

    // HOLD freezes level with sw released
    cyc(1'b1, 1'b0, MODE_HOLD);
    cyc(1'b0, 1'b1, MODE_HOLD);
    cyc(1'b0, 1'b1, MODE_HOLD);
    repeat (20) cyc(1'b0, 1'b0, MODE_HOLD);
    settle();
    chk("hold_level", level1, 2);
    chk("hold_lamps", lamps1, 15);
    cyc(1'b0, 1'b1, MODE_HOLD);
    settle();
    chk("hold_resume", level1, 3);

    // Reset mid-dwell at DWELL=4: level 2, timer 2
    cyc(1'b1, 1'b0, MODE_DECAY);
    repeat (10) cyc(1'b0, 1'b1, MODE_DECAY);
    settle();
    chk("pre_abort_level", level4, 2);
    cyc(1'b1, 1'b1, MODE_DECAY);
    settle();
    chk("abort_level", level4, 0);
    chk("abort_lamps", lamps4, 0);
    chk("abort_wrap", wrap4, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b1, MODE_DECAY);
      settle();
      if (i == 3) chk("post_abort_3", level4, 0);
      if (i == 4) chk("post_abort_4", level4, 1);
    end

    // Mode change CLEAR->HOLD on the same edge sw drops
    cyc(1'b1, 1'b0, MODE_CLEAR);
    cyc(1'b0, 1'b1, MODE_CLEAR);
    cyc(1'b0, 1'b1, MODE_CLEAR);
    cyc(1'b0, 1'b0, MODE_HOLD);
    settle();
    chk("modechg_level", level1, 2);
    chk("modechg_wrap", wrap1, 0);

    // Randomized run against the model
    s_s  = 1'b0;
    md_s = MODE_DECAY;
    for (int i = 0; i < 1500; i++) begin
      r_s = ($urandom_range(99) == 0);
      if ($urandom_range(24) == 0) md_s = 2'($urandom_range(3));
      if ($urandom_range(6) == 0) s_s = ~s_s;
      cyc(r_s, s_s, md_s);
    end

    cyc(1'b0, 1'b0, md_s);
    repeat (3) @(posedge CLK);
    #3;
    chk("sb_drain_dwell1", q1.size(), 0);
    chk("sb_drain_dwell4", q4.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
